// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and constants for the convolution sequencing controller.
package conv_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_GAP,
        S_DONE
    } conv_seq_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic OWN_KERNEL = 1'b0;
    localparam logic OWN_HOST   = 1'b1;
endpackage

// File: rtl/conv_seq_rd_arb.sv
// conv_seq_rd_arb: kernel-priority arbiter for the shared v0 read port,
// with a 1-bit owner register steering the return data.
module conv_seq_rd_arb
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic              k_rd_en,
    output logic [DATA_W-1:0] k_rd_data,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic              h_rd_en,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rd_data,
    output logic              h_rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data
);
    logic owner_q, owner_d;

    always_comb begin
        h_gnt      = h_rd_en & ~k_rd_en;
        mem_addr   = k_rd_en ? k_addr : h_addr;
        mem_rd_en  = k_rd_en | h_rd_en;
        owner_d    = h_gnt ? OWN_HOST : OWN_KERNEL;
        k_rd_data  = mem_rd_data;
        h_rd_data  = mem_rd_data;
        h_rd_valid = owner_q == OWN_HOST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) owner_q <= OWN_KERNEL;
        else     owner_q <= owner_d;
    end
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: batch sequencer issuing timed tstart pulses to the convolution kernel.
// Optional v1 write-count check enabled by defining CONV_SEQ_WRCHECK_EN.
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int KERNEL_LAT = 64,
    parameter int GAP_CYC    = 2,
    parameter int EXP_WRITES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_jobs,
    output logic              tstart,
    input  logic [ADDR_W-1:0] k_v0_addr,
    input  logic              k_v0_rd_en,
    output logic [DATA_W-1:0] k_v0_rd_data,
    input  logic              k_v1_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic              h_rd_en,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rd_data,
    output logic              h_rd_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        job_idx,
    output logic              err
);
    localparam int CNT_W = $clog2((KERNEL_LAT > GAP_CYC ? KERNEL_LAT : GAP_CYC) + 1);

    conv_seq_state_t  state_q, state_d;
    logic [7:0]       jobs_q, jobs_d, job_idx_q, job_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_last, clr_err;

    always_comb begin
        state_d   = state_q;
        jobs_d    = jobs_q;
        job_idx_d = job_idx_q;
        cnt_d     = cnt_q;
        clr_err   = 1'b0;
        run_last  = state_q == S_RUN && cnt_q == CNT_W'(KERNEL_LAT);
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                jobs_d    = cmd_jobs;
                job_idx_d = '0;
                clr_err   = 1'b1;
                state_d   = cmd_jobs == 8'd0 ? S_DONE : S_START;
            end
            S_START: begin
                cnt_d   = CNT_W'(1);
                state_d = S_RUN;
            end
            S_RUN: if (run_last) begin
                cnt_d = CNT_W'(1);
                if (job_idx_q == jobs_q - 8'd1) state_d = S_DONE;
                else begin
                    job_idx_d = job_idx_q + 8'd1;
                    state_d   = S_GAP;
                end
            end else cnt_d = cnt_q + CNT_W'(1);
            S_GAP: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(GAP_CYC) ? S_START : S_GAP;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            jobs_q    <= '0;
            job_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            jobs_q    <= jobs_d;
            job_idx_q <= job_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_ready = state_q == S_IDLE;
    assign tstart    = state_q == S_START;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign job_idx   = job_idx_q;

`ifdef CONV_SEQ_WRCHECK_EN
    // Counter must cover START plus every RUN cycle.
    localparam int WC_W = $clog2(KERNEL_LAT + 2);
    logic [WC_W-1:0] wr_cnt_q, wr_cnt_d, wr_tot;
    logic            err_q, err_d;

    always_comb begin
        wr_tot   = wr_cnt_q + WC_W'(k_v1_wr_en);
        wr_cnt_d = state_q == S_START ? WC_W'(k_v1_wr_en) : state_q == S_RUN ? wr_tot : wr_cnt_q;
        err_d    = clr_err ? 1'b0 : (run_last && int'(wr_tot) != EXP_WRITES) ? 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_wr;
    assign unused_wr = k_v1_wr_en ^ clr_err ^ (EXP_WRITES != 0);
    assign err       = 1'b0;
`endif

    conv_seq_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .k_addr     (k_v0_addr),
        .k_rd_en    (k_v0_rd_en),
        .k_rd_data  (k_v0_rd_data),
        .h_addr     (h_addr),
        .h_rd_en    (h_rd_en),
        .h_gnt      (h_gnt),
        .h_rd_data  (h_rd_data),
        .h_rd_valid (h_rd_valid),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_data(mem_rd_data)
    );
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed checks of sequencing timing, arbitration and reset.
module tb_conv_seq_ctrl;
    localparam int LAT = 64;
    localparam int GAP = 2;
    localparam int PER = 1 + LAT + GAP;
`ifdef CONV_SEQ_WRCHECK_EN
    localparam bit WRCHK = 1'b1;
`else
    localparam bit WRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_jobs = '0;
    logic        tstart;
    logic [7:0]  k_v0_addr = '0;
    logic        k_v0_rd_en = 1'b0;
    logic [31:0] k_v0_rd_data;
    logic        k_v1_wr_en = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = '0;
    logic [7:0]  h_addr = '0;
    logic        h_rd_en = 1'b0, h_gnt;
    logic [31:0] h_rd_data;
    logic        h_rd_valid, busy, done, err;
    logic [7:0]  job_idx;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= {24'hA50000, mem_addr};

    conv_seq_ctrl #(.KERNEL_LAT(LAT), .GAP_CYC(GAP), .EXP_WRITES(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_jobs(cmd_jobs),
        .tstart(tstart),
        .k_v0_addr(k_v0_addr), .k_v0_rd_en(k_v0_rd_en), .k_v0_rd_data(k_v0_rd_data),
        .k_v1_wr_en(k_v1_wr_en),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .h_addr(h_addr), .h_rd_en(h_rd_en), .h_gnt(h_gnt),
        .h_rd_data(h_rd_data), .h_rd_valid(h_rd_valid),
        .busy(busy), .done(done), .job_idx(job_idx), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issues one command; the kernel model strobes v1 writes for nwr cycles from each tstart.
    task automatic run_cmd(input logic [7:0] n, input int nwr, input bit exp_err);
        int ts_cnt = 0, dn_cnt = 0, dn_at = -1, rd_at = -1, wr_left = 0;
        step();
        cmd_valid = 1'b1;
        cmd_jobs  = n;
        #1;
        chk("ready_idle", cmd_ready, 1);
        for (int c = 1; c < 1000 && rd_at < 0; c++) begin
            step();
            cmd_valid = 1'b0;
            if (c == 1) begin
                chk("busy_run", busy, 1);
                chk("err_clr", err, 0);
            end
            if (tstart) begin
                chk("tstart_cyc", c, 1 + ts_cnt * PER);
                chk("tstart_idx", job_idx, ts_cnt);
                ts_cnt++;
                wr_left = nwr;
            end
            k_v1_wr_en = wr_left > 0;
            if (wr_left > 0) wr_left--;
            if (done) begin
                dn_cnt++;
                dn_at = c;
            end
            if (cmd_ready) rd_at = c;
        end
        k_v1_wr_en = 1'b0;
        chk("tstart_cnt", ts_cnt, n);
        chk("done_cnt", dn_cnt, 1);
        chk("done_at", dn_at, n == 0 ? 1 : PER * (n - 1) + LAT + 2);
        chk("ready_at", rd_at, n == 0 ? 2 : PER * (n - 1) + LAT + 3);
        chk("job_idx_end", job_idx, n == 0 ? 0 : n - 1);
        chk("err_end", err, exp_err);
    endtask

    initial begin
        int ts_cnt, bz_cnt;
        step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tstart", tstart, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", job_idx, 0);
        chk("rst_err", err, 0);
        chk("rst_hval", h_rd_valid, 0);
        rst = 1'b0;

        run_cmd(8'd1, 64, 1'b0);
        run_cmd(8'd3, 64, 1'b0);
        run_cmd(8'd0, 64, 1'b0);

        step();
        h_addr = 8'h10; h_rd_en = 1'b1; k_v0_addr = 8'h20; k_v0_rd_en = 1'b1;
        #1;
        chk("cf_addr_k", mem_addr, 8'h20);
        chk("cf_gnt0", h_gnt, 0);
        chk("cf_rden", mem_rd_en, 1);
        step();
        k_v0_rd_en = 1'b0;
        #1;
        chk("cf_kdata", k_v0_rd_data, 32'hA5000020);
        chk("cf_hval0", h_rd_valid, 0);
        chk("cf_gnt1", h_gnt, 1);
        chk("cf_addr_h", mem_addr, 8'h10);
        step();
        h_rd_en = 1'b0;
        #1;
        chk("cf_hval1", h_rd_valid, 1);
        chk("cf_hdata", h_rd_data, 32'hA5000010);
        step();
        chk("cf_hval_end", h_rd_valid, 0);

        run_cmd(8'd1, 63, WRCHK);
        run_cmd(8'd2, 64, 1'b0);

        step();
        cmd_valid = 1'b1;
        cmd_jobs  = 8'd3;
        for (int c = 1; c <= 31; c++) begin
            step();
            cmd_valid = 1'b0;
        end
        rst = 1'b1;
        k_v0_addr = 8'h33; k_v0_rd_en = 1'b1; h_addr = 8'h44; h_rd_en = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ready", cmd_ready, 1);
        chk("mr_idx", job_idx, 0);
        chk("mr_tstart", tstart, 0);
        chk("mr_gnt", h_gnt, 0);
        chk("mr_rden", mem_rd_en, 1);
        chk("mr_addr", mem_addr, 8'h33);
        step();
        rst = 1'b0;
        k_v0_rd_en = 1'b0;
        h_rd_en = 1'b0;
        ts_cnt = 0;
        bz_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (tstart) ts_cnt++;
            if (busy) bz_cnt++;
        end
        chk("mr_no_tstart", ts_cnt, 0);
        chk("mr_no_busy", bz_cnt, 0);
        run_cmd(8'd1, 64, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
